serial_add_sequencer: RTL and testbench

//  Sequences and shares the bit-serial adder between two requesters (order unit = port 0, accumulator = port 1).

---
 rtl/serial_add_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_serial_add_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer
//   Shares one bit-serial adder between two requesters (port 0 = order unit,
//   port 1 = accumulator). A granted operand pair is streamed LSB-first into
//   the adder. One zero guard bit follows, so the adder emits and clears its
//   carry. The delayed serial sum is collected back into a parallel result,
//   which is reported with a one-cycle done pulse.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   req[1:0]            level requests, held until the matching gnt bit pulses
//   opa0/opb0/opa1/opb1 operands, sampled only in the grant cycle
//   gnt[1:0]            one-hot grant pulse (operands captured)
//   busy                sequencer occupied (FLUSH, SHIFT..DONE)
//   done, done_id       result valid pulse and owning requester
//   result, carry_out   sum mod 2^WORD_BITS and carry, held until next done
//   add_a, add_b        registered serial operands to the adder
//   add_sum             serial sum from the adder, ADD_LAT clocks late
//
// state | meaning
// ------+---------------------------------------------------------------
// FLUSH | drive zeros ADD_LAT+1 cycles to clear adder carry, then IDLE
// IDLE  | arbitrate and grant
// SHIFT | stream operand bit cnt to the adder
// GUARD | one zero bit; adder emits carry as sum bit WORD_BITS
// DRAIN | ADD_LAT zero cycles while the last sum bits arrive
// DONE  | result valid; arbitrate again (re-grant without a gap)

module serial_add_sequencer #(
    parameter int WORD_BITS = 17,
    parameter int ADD_LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req,
    input  logic [WORD_BITS-1:0] opa0,
    input  logic [WORD_BITS-1:0] opb0,
    input  logic [WORD_BITS-1:0] opa1,
    input  logic [WORD_BITS-1:0] opb1,
    output logic [1:0]           gnt,
    output logic                 busy,
    output logic                 done,
    output logic                 done_id,
    output logic [WORD_BITS-1:0] result,
    output logic                 carry_out,
    output logic                 add_a,
    output logic                 add_b,
    input  logic                 add_sum
);

    localparam int CW = $clog2(WORD_BITS + ADD_LAT + 2);
    localparam logic [CW-1:0] FLUSH_TC  = CW'(ADD_LAT);
    localparam logic [CW-1:0] SHIFT_TC  = CW'(WORD_BITS - 1);
    localparam logic [CW-1:0] DRAIN_TC  = CW'(ADD_LAT - 1);
    localparam logic [CW-1:0] CAP_START = CW'(ADD_LAT);

    typedef enum logic [2:0] {
        S_FLUSH, S_IDLE, S_SHIFT, S_GUARD, S_DRAIN, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   rr_q, rr_d;
    logic                   owner_q, owner_d;
    logic [WORD_BITS-1:0]   sh_a_q, sh_a_d, sh_b_q, sh_b_d;
    logic [WORD_BITS:0]     col_q, col_d, col_shift;
    logic [WORD_BITS-1:0]   result_q, result_d;
    logic                   carry_q, carry_d;
    logic                   add_a_q, add_a_d, add_b_q, add_b_d;
    logic [1:0]             gnt_c;
    logic                   grant_idx;
    logic [WORD_BITS-1:0]   sel_a, sel_b;

    always_comb begin
        // tie goes to the requester that was not granted last
        grant_idx = 1'b0;
        case (req)
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~rr_q;
            default: grant_idx = 1'b0;
        endcase
        sel_a = grant_idx ? opa1 : opa0;
        sel_b = grant_idx ? opb1 : opb0;
    end

    // sum bits arrive LSB first; shifting in at the MSB leaves bit k at
    // position k after WORD_BITS+1 captures
    assign col_shift = {add_sum, col_q[WORD_BITS:1]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        rr_d     = rr_q;
        owner_d  = owner_q;
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        col_d    = col_q;
        result_d = result_q;
        carry_d  = carry_q;
        add_a_d  = 1'b0;
        add_b_d  = 1'b0;
        gnt_c    = 2'b00;

        case (state_q)
            S_FLUSH: begin
                if (cnt_q == FLUSH_TC) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_IDLE, S_DONE: begin
                cnt_d = '0;
                if (req != 2'b00) begin
                    gnt_c[grant_idx] = 1'b1;
                    rr_d    = grant_idx;
                    owner_d = grant_idx;
                    add_a_d = sel_a[0];
                    add_b_d = sel_b[0];
                    sh_a_d  = sel_a >> 1;
                    sh_b_d  = sel_b >> 1;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (cnt_q >= CAP_START) col_d = col_shift;
                if (cnt_q == SHIFT_TC) begin
                    state_d = S_GUARD;
                    cnt_d   = '0;
                end else begin
                    add_a_d = sh_a_q[0];
                    add_b_d = sh_b_q[0];
                    sh_a_d  = sh_a_q >> 1;
                    sh_b_d  = sh_b_q >> 1;
                end
            end
            S_GUARD: begin
                col_d   = col_shift;
                state_d = S_DRAIN;
                cnt_d   = '0;
            end
            S_DRAIN: begin
                col_d = col_shift;
                if (cnt_q == DRAIN_TC) begin
                    result_d = col_shift[WORD_BITS-1:0];
                    carry_d  = col_shift[WORD_BITS];
                    state_d  = S_DONE;
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d = S_FLUSH;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_FLUSH;
            cnt_q    <= '0;
            rr_q     <= 1'b1;
            owner_q  <= 1'b0;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            col_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            add_a_q  <= 1'b0;
            add_b_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            col_q    <= col_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            add_a_q  <= add_a_d;
            add_b_q  <= add_b_d;
        end
    end

    // a cycle with reset asserted must not announce a grant or a result
    assign gnt       = rst_n ? gnt_c : 2'b00;
    assign done      = rst_n && (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign done_id   = owner_q;
    assign result    = result_q;
    assign carry_out = carry_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
module tb_serial_add_sequencer;
    localparam int W   = 17;
    localparam int L   = 2;
    localparam int LAT = W + L + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req = 2'b00;
    logic [W-1:0] opa0 = '0, opb0 = '0, opa1 = '0, opb1 = '0;
    logic [1:0]   gnt;
    logic         busy, done, done_id, carry_out, add_a, add_b, add_sum;
    logic [W-1:0] result;

    serial_add_sequencer #(.WORD_BITS(W), .ADD_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .opa0(opa0), .opb0(opb0), .opa1(opa1), .opb1(opb1),
        .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
        .result(result), .carry_out(carry_out),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum)
    );

    always #5 clk = ~clk;

    // behavioural serial adder: full adder with carry register, sum delayed L clocks
    logic [L-1:0] sum_pipe = '0;
    logic         carry_m  = 1'b0;
    always @(posedge clk) begin
        sum_pipe <= {sum_pipe[L-2:0], add_a ^ add_b ^ carry_m};
        carry_m  <= (add_a & add_b) | (add_a & carry_m) | (add_b & carry_m);
    end
    assign add_sum = sum_pipe[L-1];

    int     total = 0;
    int     bad   = 0;
    longint cyc     = 0;
    longint gnt_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input string nm, input logic [1:0] expg);
        int n = 0;
        @(negedge clk);
        while (gnt == 2'b00 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_gnt"}, gnt, expg);
        gnt_cyc = cyc;
    endtask

    task automatic wait_done(input string nm, input bit id, input logic [W-1:0] res,
                             input bit c, input logic [1:0] expg);
        int n = 0;
        @(negedge clk);
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_lat"},   cyc - gnt_cyc, LAT);
        chk({nm, "_id"},    done_id, id);
        chk({nm, "_res"},   result, res);
        chk({nm, "_carry"}, carry_out, c);
        chk({nm, "_regnt"}, gnt, expg);
        if (gnt != 2'b00) gnt_cyc = cyc;
    endtask

    // caller sits just after a posedge with the sequencer idle
    task automatic run_op(input string nm, input bit p, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] res, input bit c);
        if (p) begin opa1 = a; opb1 = b; end
        else   begin opa0 = a; opb0 = b; end
        req[p] = 1'b1;
        wait_gnt(nm, p ? 2'b10 : 2'b01);
        step;
        req[p] = 1'b0;
        opa0 = ~opa0; opb0 = ~opb0; opa1 = ~opa1; opb1 = ~opb1;
        wait_done(nm, p, res, c, 2'b00);
        step;
    endtask

    // serial stream monitor and result-hold check
    bit           mon_en = 1'b0;
    int           mon_k  = -1;
    logic [W-1:0] ma = '0, mb = '0, hold_res = '0;
    logic         hold_c = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            logic ea, eb;
            ea = 1'b0;
            eb = 1'b0;
            if (mon_k >= 0) begin
                ea = ma[mon_k];
                eb = mb[mon_k];
            end
            chk("add_a_stream", add_a, ea);
            chk("add_b_stream", add_b, eb);
            if (!done) begin
                chk("result_hold", result, hold_res);
                chk("carry_hold", carry_out, hold_c);
            end else begin
                hold_res = result;
                hold_c   = carry_out;
            end
            if (!rst_n) begin
                mon_k = -1; hold_res = '0; hold_c = 1'b0;
            end else if (gnt[0]) begin
                ma = opa0; mb = opb0; mon_k = 0;
            end else if (gnt[1]) begin
                ma = opa1; mb = opb1; mon_k = 0;
            end else if (mon_k >= 0) begin
                mon_k = (mon_k == W - 1) ? -1 : mon_k + 1;
            end
        end
    end

    typedef struct {
        bit           port;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        bit           c;
    } vec_t;
    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 17'd5,       17'd3,       17'd8,       1'b0};
        vecs[1] = '{1'b0, 17'h1FFFF,   17'd1,       17'd0,       1'b1};
        vecs[2] = '{1'b0, 17'd2,       17'd2,       17'd4,       1'b0};
        vecs[3] = '{1'b1, 17'h1FFFF,   17'h1FFFF,   17'h1FFFE,   1'b1};
        vecs[4] = '{1'b1, 17'd0,       17'd0,       17'd0,       1'b0};
        vecs[5] = '{1'b0, 17'h15555,   17'h0AAAA,   17'h1FFFF,   1'b0};
        vecs[6] = '{1'b1, 17'h10000,   17'h10000,   17'd0,       1'b1};

        // reset state
        repeat (3) step;
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_carry", carry_out, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        chk("rst_busy", busy, 1);
        chk("rst_done_id", done_id, 0);

        // release with both requesting: no grant during FLUSH, tie goes to port 0
        step;
        rst_n = 1'b1;
        mon_en = 1'b1;
        opa0 = 17'd10;  opb0 = 17'd20;
        opa1 = 17'd100; opb1 = 17'd200;
        req = 2'b11;
        for (int i = 0; i < L + 1; i++) begin
            @(negedge clk);
            chk("flush_busy", busy, 1);
            chk("flush_gnt", gnt, 0);
        end
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("tie0_gnt", gnt, 2'b01);
        gnt_cyc = cyc;
        step;
        req[0] = 1'b0;
        @(negedge clk);
        chk("shift_busy", busy, 1);
        // port 1 pending since before the grant: re-granted in DONE
        wait_done("rr_a", 1'b0, 17'd30, 1'b0, 2'b10);
        step;
        // port 1 brings a new op, port 0 a new op: tie with last grant 1 -> port 0
        opa1 = 17'd1000; opb1 = 17'd2000;
        opa0 = 17'd7;    opb0 = 17'd8;
        req  = 2'b11;
        wait_done("rr_b", 1'b1, 17'd300, 1'b0, 2'b01);
        step;
        req[0] = 1'b0;
        repeat (5) step;
        // port 0 raised again mid-SHIFT: tie with last grant 0 -> port 1
        opa0 = 17'd3; opb0 = 17'd4;
        req[0] = 1'b1;
        wait_done("rr_c", 1'b0, 17'd15, 1'b0, 2'b10);
        step;
        req[1] = 1'b0;
        wait_done("rr_d", 1'b1, 17'd3000, 1'b0, 2'b01);
        step;
        req[0] = 1'b0;
        wait_done("rr_e", 1'b0, 17'd7, 1'b0, 2'b00);
        step;
        @(negedge clk);
        chk("post_idle_busy", busy, 0);
        step;

        for (int i = 0; i < 7; i++)
            run_op($sformatf("vec%0d", i), vecs[i].port, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].c);

        for (int i = 0; i < 24; i++) begin
            bit           p;
            logic [W-1:0] a, b;
            logic [W:0]   s;
            p = 1'($urandom_range(0, 1));
            a = W'($urandom);
            b = W'($urandom);
            s = {1'b0, a} + {1'b0, b};
            run_op($sformatf("rnd%0d", i), p, a, b, s[W-1:0], s[W]);
        end

        // reset in SHIFT bit 10 of an op that leaves a carry in the adder
        opa0 = 17'h1FFFF; opb0 = 17'd1;
        req[0] = 1'b1;
        wait_gnt("abort", 2'b01);
        step;
        req[0] = 1'b0;
        repeat (10) step;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_rst_gnt", gnt, 0);
        chk("abort_rst_done", done, 0);
        step;
        rst_n = 1'b1;
        for (int i = 0; i < L + 1; i++) begin
            @(negedge clk);
            chk("abort_flush_busy", busy, 1);
            chk("abort_flush_done", done, 0);
            chk("abort_result", result, 0);
        end
        @(negedge clk);
        chk("abort_idle_busy", busy, 0);
        chk("abort_idle_done", done, 0);
        step;
        run_op("after_abort", 1'b0, 17'd1, 17'd1, 17'd2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
